// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock divider bank.
package clk_div_pkg;

    localparam int CH_W = 3;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_PENDING = 2'd3
    } state_e;

endpackage

// File: rtl/clk_div_bank_if.sv
// Reconfiguration handshake between a controller and the divider bank.
interface clk_div_bank_if
    import clk_div_pkg::*;
#(
    parameter int DIV_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_en;

    modport master (output cfg_valid, cfg_ch, cfg_div, cfg_en, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_en, output cfg_ready);
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: free-running counter, ratio/enable registers and
// registered outclk/tick. A new configuration only lands on the wrap cycle.
module clk_div_chan #(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic             i_refclk,
    input  logic             i_rst,
    input  logic             i_commit,
    input  logic [DIV_W-1:0] i_new_div,
    input  logic             i_new_en,
    output logic             o_wrap,
    output logic             o_outclk,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_en;
    logic             r_outclk;
    logic             r_tick;
    logic             w_wrap;

    assign w_wrap   = (r_cnt == (r_div - DIV_W'(1)));
    assign o_wrap   = w_wrap;
    assign o_outclk = r_outclk;
    assign o_tick   = r_tick;

    // Counter, configuration and output registers; the counter keeps running
    // while disabled so that the commit point is always defined.
    always_ff @(posedge i_refclk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= {DIV_W{1'b0}};
            r_div    <= DIV_W'(DEF_DIV);
            r_en     <= 1'b1;
            r_outclk <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_outclk <= (r_cnt < (r_div >> 1)) && r_en;
            r_tick   <= (r_cnt == {DIV_W{1'b0}}) && r_en;
            if (w_wrap) begin
                r_cnt <= {DIV_W{1'b0}};
                if (i_commit) begin
                    r_div <= i_new_div;
                    r_en  <= i_new_en;
                end
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CLKS programmable clock dividers with a single-outstanding
// reconfiguration port and a lock indicator.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CLKS    = 3,
    parameter int DIV_W       = 8,
    parameter int DEF_DIV     = 2,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                refclk,
    input  logic                rst,
    clk_div_bank_if.slave       cfg,
    output logic [NUM_CLKS-1:0] outclk,
    output logic [NUM_CLKS-1:0] tick,
    output logic                locked
);

    localparam int LCNT_W = $clog2(LOCK_CYCLES + 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [LCNT_W-1:0]   r_lcnt;
    logic [LCNT_W-1:0]   w_lcnt_nxt;
    logic                r_ready;
    logic                r_locked;
    logic [CH_W-1:0]     r_pend_ch;
    logic [DIV_W-1:0]    r_pend_div;
    logic                r_pend_en;
    logic                w_accept;
    logic                w_ch_ok;
    logic                w_load_pend;
    logic                w_commit_now;
    logic [NUM_CLKS-1:0] w_chan_commit;
    logic [NUM_CLKS-1:0] w_wrap;

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        if (d < DIV_W'(2)) begin
            clamp_div = DIV_W'(2);
        end else begin
            clamp_div = d;
        end
    endfunction

    assign w_accept     = cfg.cfg_valid && r_ready;
    assign w_ch_ok      = ({1'b0, cfg.cfg_ch} < (CH_W + 1)'(NUM_CLKS));
    assign w_commit_now = |(w_chan_commit & w_wrap);
    assign cfg.cfg_ready = r_ready;
    assign locked        = r_locked;

    for (genvar i = 0; i < NUM_CLKS; i++) begin : g_chan
        assign w_chan_commit[i] = (r_state == ST_PENDING) && (r_pend_ch == CH_W'(i));

        clk_div_chan #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .i_refclk  (refclk),
            .i_rst     (rst),
            .i_commit  (w_chan_commit[i]),
            .i_new_div (r_pend_div),
            .i_new_en  (r_pend_en),
            .o_wrap    (w_wrap[i]),
            .o_outclk  (outclk[i]),
            .o_tick    (tick[i])
        );
    end

    // Control FSM next-state and lock-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_lcnt_nxt  = r_lcnt;
        w_load_pend = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_state_nxt = ST_COUNT;
                w_lcnt_nxt  = {LCNT_W{1'b0}};
            end
            ST_COUNT: begin
                if (w_accept && w_ch_ok) begin
                    w_state_nxt = ST_PENDING;
                    w_load_pend = 1'b1;
                end else if (r_lcnt == LCNT_W'(LOCK_CYCLES - 1)) begin
                    w_state_nxt = ST_LOCKED;
                end else begin
                    w_lcnt_nxt = r_lcnt + LCNT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (w_accept && w_ch_ok) begin
                    w_state_nxt = ST_PENDING;
                    w_load_pend = 1'b1;
                end else begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_PENDING: begin
                if (w_commit_now) begin
                    w_state_nxt = ST_COUNT;
                    w_lcnt_nxt  = {LCNT_W{1'b0}};
                end else begin
                    w_state_nxt = ST_PENDING;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_lcnt_nxt  = {LCNT_W{1'b0}};
            end
        endcase
    end

    // FSM state, registered handshake/lock outputs and the pending request.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_lcnt     <= {LCNT_W{1'b0}};
            r_ready    <= 1'b0;
            r_locked   <= 1'b0;
            r_pend_ch  <= {CH_W{1'b0}};
            r_pend_div <= DIV_W'(DEF_DIV);
            r_pend_en  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_lcnt   <= w_lcnt_nxt;
            r_ready  <= (w_state_nxt == ST_COUNT) || (w_state_nxt == ST_LOCKED);
            r_locked <= (w_state_nxt == ST_LOCKED);
            if (w_load_pend) begin
                r_pend_ch  <= cfg.cfg_ch;
                r_pend_div <= clamp_div(cfg.cfg_div);
                r_pend_en  <= cfg.cfg_en;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank against a time-based reference model.
module tb_clk_div_bank;

    localparam int NUM_CLKS    = 3;
    localparam int DIV_W       = 8;
    localparam int DEF_DIV     = 2;
    localparam int LOCK_CYCLES = 16;

    logic                refclk;
    logic                rst;
    logic [NUM_CLKS-1:0] outclk;
    logic [NUM_CLKS-1:0] tick;
    logic                locked;

    clk_div_bank_if #(.DIV_W(DIV_W)) cfg_if ();

    clk_div_bank #(
        .NUM_CLKS    (NUM_CLKS),
        .DIV_W       (DIV_W),
        .DEF_DIV     (DEF_DIV),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .cfg    (cfg_if),
        .outclk (outclk),
        .tick   (tick),
        .locked (locked)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    int checks = 0;
    int errors = 0;

    // Reference model: each channel's period started at cycle m_start with ratio
    // m_div, so its phase in cycle c is (c - m_start) mod m_div.
    int cyc;
    int m_start [NUM_CLKS];
    int m_div   [NUM_CLKS];
    bit m_en    [NUM_CLKS];
    bit m_pend;
    int m_pch;
    int m_pdiv;
    bit m_pen;
    int m_lock_start;
    bit m_accepted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CLKS; i++) begin
            m_start[i] = 0;
            m_div[i]   = DEF_DIV;
            m_en[i]    = 1'b1;
        end
        m_pend       = 1'b0;
        m_lock_start = 1;
        cyc          = 0;
    endtask

    task automatic step();
        logic [NUM_CLKS-1:0] nout;
        logic [NUM_CLKS-1:0] ntick;
        int ph;
        int d;
        nout = '0;
        ntick = '0;
        m_accepted = 1'b0;
        for (int i = 0; i < NUM_CLKS; i++) begin
            ph = (cyc - m_start[i]) % m_div[i];
            nout[i]  = m_en[i] && (ph < m_div[i] / 2);
            ntick[i] = m_en[i] && (ph == 0);
        end
        if (m_pend) begin
            if (((cyc - m_start[m_pch]) % m_div[m_pch]) == m_div[m_pch] - 1) begin
                m_div[m_pch]   = m_pdiv;
                m_en[m_pch]    = m_pen;
                m_start[m_pch] = cyc + 1;
                m_pend         = 1'b0;
                m_lock_start   = cyc + 1;
            end
        end else if (cyc >= 1 && cfg_if.cfg_valid) begin
            m_accepted = 1'b1;
            if (int'(cfg_if.cfg_ch) < NUM_CLKS) begin
                d      = int'(cfg_if.cfg_div);
                m_pend = 1'b1;
                m_pch  = int'(cfg_if.cfg_ch);
                m_pdiv = (d < 2) ? 2 : d;
                m_pen  = cfg_if.cfg_en;
            end
        end
        @(posedge refclk);
        #1;
        cyc++;
        check("outclk", 32'(outclk), 32'(nout));
        check("tick",   32'(tick),   32'(ntick));
        check("locked", 32'(locked), 32'(!m_pend && (cyc >= m_lock_start + LOCK_CYCLES)));
        check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(!m_pend));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic request(input int ch, input int dv, input bit en);
        int n;
        n = 0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 3'(ch);
        cfg_if.cfg_div   = 8'(dv);
        cfg_if.cfg_en    = en;
        step();
        while (!m_accepted && n < 200) begin
            step();
            n++;
        end
        cfg_if.cfg_valid = 1'b0;
        if (!m_accepted) begin
            checks++;
            errors++;
            $error("FAIL req_timeout: observed no acceptance expected acceptance within 200 cycles");
        end
    endtask

    task automatic run_until_idle();
        int n;
        n = 0;
        while (m_pend && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        repeat (2) @(posedge refclk);
        #1;
        check("rst_outclk", 32'(outclk), 32'd0);
        check("rst_tick",   32'(tick),   32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_ready",  32'(cfg_if.cfg_ready), 32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = 3'd0;
        cfg_if.cfg_div   = 8'd0;
        cfg_if.cfg_en    = 1'b0;
        #1;
        do_reset();
        run(LOCK_CYCLES + 4);

        run($urandom_range(0, 5));
        request(1, 8, 1'b1);
        run_until_idle();
        run(LOCK_CYCLES + 4);

        request(2, 1, 1'b1);
        run_until_idle();
        run(10);
        request(2, 7, 1'b1);
        run_until_idle();
        run(LOCK_CYCLES + 4);

        // Back-to-back requests: the second one stalls until the first commits.
        request(0, 4, 1'b1);
        request(1, 3, 1'b1);
        run_until_idle();
        run(12);

        request(0, 6, 1'b0);
        run_until_idle();
        run(10);
        request(0, 4, 1'b1);
        run_until_idle();
        run(LOCK_CYCLES + 4);

        request(5, 9, 1'b1);
        run(10);
        request(2, 7, 1'b1);
        run_until_idle();
        run(8);

        // Reset while a request is pending on channel 0.
        request(0, 10, 1'b1);
        do_reset();
        run(LOCK_CYCLES + 6);

        for (int k = 0; k < 10; k++) begin
            run($urandom_range(0, 6));
            request($urandom_range(0, 5), $urandom_range(0, 12), ($urandom_range(0, 3) != 0));
        end
        run_until_idle();
        run(LOCK_CYCLES + 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NUM_CLKS, default 3, number of divided output clocks (legal 1..8).
REQ-002 Parameter DIV_W, default 8, width of each channel divide ratio.
REQ-003 Parameter DEF_DIV, default 2, divide ratio loaded into every channel at reset.
REQ-004 Parameter LOCK_CYCLES, default 16, refclk cycles of stable running required before locked asserts.
REQ-005 refclk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 cfg_valid  input  1  reconfiguration request valid.
REQ-008 cfg_ready  output  1  block can accept a request this cycle.
REQ-009 cfg_ch  input  3  target channel index.
REQ-010 cfg_div  input  DIV_W  new divide ratio for target channel.
REQ-011 cfg_en  input  1  new enable for target channel.
REQ-012 outclk  output  NUM_CLKS  registered divided clocks, bit i = channel i.
REQ-013 tick  output  NUM_CLKS  one-cycle strobe, bit i high on the cycle outclk[i] rises.
REQ-014 locked  output  1  all channels running at their committed configuration.

Function
REQ-015 Each channel has counter cnt (DIV_W bits) cycling 0..div-1, wrapping to 0 after div-1.
REQ-016 outclk[i] is registered as (cnt < div>>1) AND en, giving high for floor(div/2) cycles, low for the remainder (50% for even div).
REQ-017 tick[i] is registered as (cnt == 0) AND en.
REQ-018 cfg_div of 0 or 1 is clamped to 2 on acceptance.
REQ-019 A request is accepted on a cycle with cfg_valid and cfg_ready both high.
REQ-020 cfg_ready is low while a request is pending; only one request outstanding; cfg_valid while not ready is stalled, not dropped.
REQ-021 Accepted request with cfg_ch >= NUM_CLKS is discarded; no pending state, locked unaffected.
REQ-022 Accepted valid request is held pending and committed on the target channel's wrap cycle (cnt == div-1), so the new ratio starts at cnt=0 with no runt pulse.
REQ-023 Committing a disabled->enabled change starts the channel at cnt=0 on the next cycle; a disabled channel's counter still runs at its ratio so commit timing is defined.
REQ-024 Request identical to current config still follows REQ-022 and drops locked.
REQ-025 Control FSM states: INIT, COUNT, LOCKED, PENDING.
REQ-026 INIT: one cycle after reset release, then COUNT with lock counter cleared.
REQ-027 COUNT: lock counter increments each cycle; at LOCK_CYCLES-1 go to LOCKED.
REQ-028 LOCKED: locked=1; on accepted valid request go to PENDING, locked=0 the next cycle.
REQ-029 PENDING: on commit cycle go to COUNT with lock counter cleared; cfg_ready returns high the cycle after commit.
REQ-030 Requests may also be accepted in COUNT; they move the FSM to PENDING.
REQ-031 Non-target channels continue undisturbed through any reconfiguration.

Reset
REQ-032 During rst: cnt=0, div=DEF_DIV, en=1 for all channels, outclk=0, tick=0, locked=0, cfg_ready=0, FSM=INIT.
REQ-033 cfg_ready goes high in the first cycle after INIT.
REQ-034 rst asserted mid-reconfiguration discards the pending request; no partial commit.

Structure
REQ-035 Package clk_div_pkg holds the FSM state enum and the channel-index width constant.
REQ-036 Sub-module clk_div_chan implements one channel (counter, ratio/enable registers, commit, outclk/tick); instantiated NUM_CLKS times by generate.

Verification
REQ-037 Reset release, defaults -> all outclk toggle period 2, locked high exactly LOCK_CYCLES+1 cycles after release.
REQ-038 Program ch1 div=8 en=1 mid-period -> ch1 finishes current period, then 4 high/4 low; locked low until 16 cycles after commit; ch0/ch2 unchanged.
REQ-039 Program ch2 div=1 -> clamped, ch2 period 2; div=7 -> 3 high/4 low.
REQ-040 Second request while pending -> cfg_ready low, request stalls, accepted the cycle after commit of the first.
REQ-041 cfg_ch=5 with NUM_CLKS=3 -> accepted, no effect, locked stays high.
REQ-042 Assert rst during PENDING for ch0 div=10 -> after release ch0 runs period DEF_DIV, locked re-acquires normally.
